// File: rtl/udp_header_builder.sv
// udp_header_builder: prepends a 42-byte Ethernet/IPv4/UDP header to a payload stream.
// Define PANIC_TX_IP_CSUM_EN to fill in the IPv4 header checksum.
module udp_header_builder #(
  parameter int          DATA_WIDTH = 256,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter logic [47:0] DST_MAC    = 48'h02_00_00_00_00_02,
  parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
  parameter logic [7:0]  IP_TTL     = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  input  logic [31:0]           s_desc_ip_src,
  input  logic [31:0]           s_desc_ip_dest,
  input  logic [15:0]           s_desc_port_src,
  input  logic [15:0]           s_desc_port_dest,
  input  logic [15:0]           s_desc_payload_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_len_err
);

  localparam int HDR_LEN  = 42;
  localparam int HDR_FULL = HDR_LEN / KEEP_WIDTH;
  localparam int OFF      = HDR_LEN % KEEP_WIDTH;
  localparam int TAKE     = KEEP_WIDTH - OFF;
  localparam int PAD_W    = (HDR_FULL + 1) * DATA_WIDTH;
  localparam logic [1:0] HDR_LAST = 2'(HDR_FULL - 1);

  if (DATA_WIDTH != 128 && DATA_WIDTH != 256 &&
      DATA_WIDTH != 512) begin : g_bad_width
    $error("udp_header_builder: DATA_WIDTH must be 128/256/512");
  end
  if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_keep
    $error("udp_header_builder: KEEP_WIDTH must be DATA_WIDTH/8");
  end

  typedef enum logic [2:0] {
    IDLE, CALC, HDR, MERGE, FLUSH
  } state_t;

  state_t state, state_d;

  logic [31:0]           ip_src_q, ip_dst_q;
  logic [15:0]           port_src_q, port_dst_q, len_q;
  logic [15:0]           csum_q, csum_d, csum_c, csum_use;
  logic [15:0]           ip_len, udp_len;
  logic [1:0]            hdr_cnt, hdr_cnt_d;
  logic [OFF*8-1:0]      resid, resid_d, hdr_tail;
  logic [15:0]           cnt, cnt_d;
  logic [KEEP_WIDTH-1:0] flush_keep, flush_keep_d;
  logic                  err_d;
  logic                  out_ld, out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  ld, desc_fire, in_fire;
  logic [7:0]            hb [HDR_LEN];
  logic [PAD_W-1:0]      hdr_pad;
  int                    n_bytes;
  int                    hdr_base;

  function automatic logic [KEEP_WIDTH-1:0] low_mask(input int k);
    logic [KEEP_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (i < k);
    return m;
  endfunction

  assign ld        = !m_axis_tvalid || m_axis_tready;
  assign s_desc_ready  = (state == IDLE) && !rst;
  assign s_axis_tready = (state == MERGE) && ld && (len_q != 16'h0);
  assign desc_fire = s_desc_valid && s_desc_ready;
  assign in_fire   = s_axis_tvalid && s_axis_tready;
  assign ip_len    = len_q + 16'd28;
  assign udp_len   = len_q + 16'd8;

`ifdef PANIC_TX_IP_CSUM_EN
  logic [19:0] csum_sum;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;

  always_comb begin
    csum_sum = 20'h04500 + 20'(ip_len) + 20'h04000
             + 20'({IP_TTL, 8'h11})
             + 20'(ip_src_q[31:16]) + 20'(ip_src_q[15:0])
             + 20'(ip_dst_q[31:16]) + 20'(ip_dst_q[15:0]);
    csum_f1 = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
    csum_f2 = csum_f1[15:0] + 16'(csum_f1[16]);
    csum_c  = ~csum_f2;
  end
`else
  assign csum_c = 16'h0000;
`endif

  // CALC may need the header tail before csum_q is loaded
  assign csum_use = (state == CALC) ? csum_c : csum_q;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      hb[i]     = DST_MAC[47-8*i -: 8];
      hb[6 + i] = SRC_MAC[47-8*i -: 8];
    end
    hb[12] = 8'h08;
    hb[13] = 8'h00;
    hb[14] = 8'h45;
    hb[15] = 8'h00;
    hb[16] = ip_len[15:8];
    hb[17] = ip_len[7:0];
    hb[18] = 8'h00;
    hb[19] = 8'h00;
    hb[20] = 8'h40;
    hb[21] = 8'h00;
    hb[22] = IP_TTL;
    hb[23] = 8'h11;
    hb[24] = csum_use[15:8];
    hb[25] = csum_use[7:0];
    for (int i = 0; i < 4; i++) begin
      hb[26 + i] = ip_src_q[31-8*i -: 8];
      hb[30 + i] = ip_dst_q[31-8*i -: 8];
    end
    hb[34] = port_src_q[15:8];
    hb[35] = port_src_q[7:0];
    hb[36] = port_dst_q[15:8];
    hb[37] = port_dst_q[7:0];
    hb[38] = udp_len[15:8];
    hb[39] = udp_len[7:0];
    hb[40] = 8'h00;
    hb[41] = 8'h00;
    hdr_pad = '0;
    for (int i = 0; i < HDR_LEN; i++) hdr_pad[i*8 +: 8] = hb[i];
  end

  assign hdr_tail = hdr_pad[HDR_FULL*DATA_WIDTH +: OFF*8];
  assign hdr_base = int'(hdr_cnt) * DATA_WIDTH;

  always_comb begin
    n_bytes = 0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      if (s_axis_tkeep[i]) n_bytes++;
  end

  always_comb begin
    state_d      = state;
    hdr_cnt_d    = hdr_cnt;
    resid_d      = resid;
    cnt_d        = cnt;
    flush_keep_d = flush_keep;
    csum_d       = csum_q;
    err_d        = 1'b0;
    out_ld       = 1'b0;
    out_data     = '0;
    out_keep     = '0;
    out_last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (desc_fire) begin
          state_d = CALC;
          cnt_d   = '0;
        end
      end
      CALC: begin
        csum_d    = csum_c;
        hdr_cnt_d = '0;
        if (HDR_FULL > 0) begin
          state_d = HDR;
        end else begin
          state_d = MERGE;
          resid_d = hdr_tail;
        end
      end
      HDR: begin
        if (ld) begin
          out_ld   = 1'b1;
          out_data = hdr_pad[hdr_base +: DATA_WIDTH];
          out_keep = '1;
          if (hdr_cnt == HDR_LAST) begin
            state_d = MERGE;
            resid_d = hdr_tail;
          end else begin
            hdr_cnt_d = hdr_cnt + 2'd1;
          end
        end
      end
      MERGE: begin
        if (len_q == 16'h0) begin
          if (ld) begin
            out_ld   = 1'b1;
            out_data = {{(TAKE*8){1'b0}}, resid};
            out_keep = low_mask(OFF);
            out_last = 1'b1;
            err_d    = (cnt != len_q);
            state_d  = IDLE;
          end
        end else if (in_fire) begin
          out_ld   = 1'b1;
          out_data = {s_axis_tdata[TAKE*8-1:0], resid};
          out_keep = '1;
          resid_d  = s_axis_tdata[DATA_WIDTH-1 -: OFF*8];
          cnt_d    = cnt + 16'(n_bytes);
          if (s_axis_tlast) begin
            err_d = (cnt_d != len_q);
            if (n_bytes <= TAKE) begin
              out_keep = low_mask(OFF + n_bytes);
              out_last = 1'b1;
              state_d  = IDLE;
            end else begin
              flush_keep_d = low_mask(n_bytes - TAKE);
              state_d      = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (ld) begin
          out_ld   = 1'b1;
          out_data = {{(TAKE*8){1'b0}}, resid};
          out_keep = flush_keep;
          out_last = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hdr_cnt       <= '0;
      resid         <= '0;
      cnt           <= '0;
      flush_keep    <= '0;
      csum_q        <= '0;
      ip_src_q      <= '0;
      ip_dst_q      <= '0;
      port_src_q    <= '0;
      port_dst_q    <= '0;
      len_q         <= '0;
      m_len_err     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state      <= state_d;
      hdr_cnt    <= hdr_cnt_d;
      resid      <= resid_d;
      cnt        <= cnt_d;
      flush_keep <= flush_keep_d;
      csum_q     <= csum_d;
      m_len_err  <= err_d;
      if (desc_fire) begin
        ip_src_q   <= s_desc_ip_src;
        ip_dst_q   <= s_desc_ip_dest;
        port_src_q <= s_desc_port_src;
        port_dst_q <= s_desc_port_dest;
        len_q      <= s_desc_payload_len;
      end
      if (out_ld) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= out_data;
        m_axis_tkeep  <= out_keep;
        m_axis_tlast  <= out_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_header_builder.sv
// tb_udp_header_builder: randomized scoreboard bench for udp_header_builder.
// Frames are predicted byte-wise from the header rules and compared per beat.
`timescale 1ns/1ps
module tb_udp_header_builder;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam logic [47:0] DMAC = 48'h02_00_00_00_00_02;
  localparam logic [47:0] SMAC = 48'h02_00_00_00_00_01;
  localparam logic [7:0]  TTL  = 8'd64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_desc_valid;
  logic          s_desc_ready;
  logic [31:0]   s_desc_ip_src, s_desc_ip_dest;
  logic [15:0]   s_desc_port_src, s_desc_port_dest;
  logic [15:0]   s_desc_payload_len;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          m_len_err;

  udp_header_builder #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .s_desc_ip_src(s_desc_ip_src), .s_desc_ip_dest(s_desc_ip_dest),
    .s_desc_port_src(s_desc_port_src),
    .s_desc_port_dest(s_desc_port_dest),
    .s_desc_payload_len(s_desc_payload_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_len_err(m_len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       sb[$];
  beat_t       got[$];
  logic [7:0]  last_pay[$];
  int          ready_mode = 0;
  int          err_cycles = 0;
  int          exp_err_cycles = 0;
  int          bytes_seen = 0;
  logic        saw_in_ready = 1'b0;
  logic        v_seen = 1'b0;
  int          first_v_cyc = 0;
  int          acc_cyc = 0;
  beat_t       mon_e, mon_a;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mask_data(input logic [DW-1:0] d,
                                              input logic [KW-1:0] k);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < KW; i++) if (k[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Reference: whole frame as a byte list, then cut into KW-byte beats
  function automatic logic [15:0] model_frame(
    input logic [31:0] ips, input logic [31:0] ipd,
    input logic [15:0] ps, input logic [15:0] pd, input logic [15:0] dlen);
    logic [7:0]  f[$];
    logic [15:0] ipl, udl, cs;
    int          sum;
    beat_t       b;
    ipl = dlen + 16'd28;
    udl = dlen + 16'd8;
    for (int i = 0; i < 6; i++) f.push_back(DMAC[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(SMAC[47-8*i -: 8]);
    f.push_back(8'h08); f.push_back(8'h00);
    f.push_back(8'h45); f.push_back(8'h00);
    f.push_back(ipl[15:8]); f.push_back(ipl[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    f.push_back(8'h40); f.push_back(8'h00);
    f.push_back(TTL); f.push_back(8'h11);
    f.push_back(8'h00); f.push_back(8'h00);
    for (int i = 0; i < 4; i++) f.push_back(ips[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) f.push_back(ipd[31-8*i -: 8]);
    f.push_back(ps[15:8]); f.push_back(ps[7:0]);
    f.push_back(pd[15:8]); f.push_back(pd[7:0]);
    f.push_back(udl[15:8]); f.push_back(udl[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    cs = 16'h0;
`ifdef PANIC_TX_IP_CSUM_EN
    sum = 0;
    for (int k = 0; k < 10; k++) sum += int'({f[14+2*k], f[15+2*k]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    cs = ~16'(sum);
    f[24] = cs[15:8];
    f[25] = cs[7:0];
`else
    sum = 0;
`endif
    foreach (last_pay[i]) f.push_back(last_pay[i]);
    for (int s = 0; s < f.size(); s += KW) begin
      b = '0;
      for (int i = 0; i < KW; i++)
        if (s + i < f.size()) begin
          b.data[i*8 +: 8] = f[s+i];
          b.keep[i] = 1'b1;
        end
      b.last = (s + KW >= f.size());
      sb.push_back(b);
    end
    return cs + 16'(sum & 0);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && !v_seen) begin
        v_seen = 1'b1;
        first_v_cyc = cyc;
      end
      if (m_len_err) err_cycles++;
      if (s_axis_tready) saw_in_ready = 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        mon_a.data = m_axis_tdata;
        mon_a.keep = m_axis_tkeep;
        mon_a.last = m_axis_tlast;
        got.push_back(mon_a);
        bytes_seen += $countones(m_axis_tkeep);
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat keep=%h last=%b",
                   m_axis_tkeep, m_axis_tlast);
        end else begin
          mon_e = sb.pop_front();
          if (m_axis_tkeep !== mon_e.keep ||
              m_axis_tlast !== mon_e.last ||
              mask_data(m_axis_tdata, m_axis_tkeep) !== mon_e.data) begin
            n_errors++;
            $display("FAIL beat got keep=%h last=%b data=%h",
                     m_axis_tkeep, m_axis_tlast, m_axis_tdata);
            $display("  expected keep=%h last=%b data=%h",
                     mon_e.keep, mon_e.last, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    logic tog;
    tog = 1'b0;
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
      case (ready_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = tog;
        2: m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  task automatic send_desc(input logic [31:0] ips, input logic [31:0] ipd,
                           input logic [15:0] ps, input logic [15:0] pd,
                           input logic [15:0] dlen, output bit ok);
    int to;
    @(posedge clk);
    #1;
    v_seen = 1'b0;
    s_desc_valid = 1'b1;
    s_desc_ip_src = ips;
    s_desc_ip_dest = ipd;
    s_desc_port_src = ps;
    s_desc_port_dest = pd;
    s_desc_payload_len = dlen;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!s_desc_ready && to < 200);
    ok = s_desc_ready;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    s_desc_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL desc_timeout got=0 expected=1");
    end
  endtask

  task automatic run_frame(input logic [31:0] ips, input logic [31:0] ipd,
                           input logic [15:0] ps, input logic [15:0] pd,
                           input logic [15:0] dlen, input int alen,
                           input int gap);
    int pos, nb, to;
    bit ok;
    last_pay.delete();
    for (int i = 0; i < alen; i++) last_pay.push_back(8'($urandom));
    void'(model_frame(ips, ipd, ps, pd, dlen));
    got.delete();
    bytes_seen = 0;
    saw_in_ready = 1'b0;
    if (alen != int'(dlen)) exp_err_cycles++;
    send_desc(ips, ipd, ps, pd, dlen, ok);
    if (!ok) return;
    pos = 0;
    while (pos < alen) begin
      s_axis_tvalid = 1'b0;
      while (int'($urandom_range(0, 99)) < gap) begin
        @(posedge clk);
        #1;
      end
      nb = (alen - pos > KW) ? KW : alen - pos;
      for (int i = 0; i < KW; i++) begin
        s_axis_tdata[i*8 +: 8] = (i < nb) ? last_pay[pos+i]
                                          : 8'($urandom);
        s_axis_tkeep[i] = (i < nb);
      end
      s_axis_tlast = (pos + nb == alen);
      s_axis_tvalid = 1'b1;
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!s_axis_tready && to < 1000);
      if (!s_axis_tready) begin
        n_checks++;
        n_errors++;
        $display("FAIL payload_timeout got=0 expected=1");
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      pos += nb;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int to;
    to = 0;
    while (sb.size() != 0 && to < 3000) begin
      @(posedge clk);
      to++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain pending=%0d expected=0", name, sb.size());
      sb.delete();
    end
    chk({name, "_len_err"}, 64'(err_cycles), 64'(exp_err_cycles));
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_cs;
    logic [15:0] dlen;
    bit ok;
    s_desc_valid = 1'b0;
    s_desc_ip_src = '0;
    s_desc_ip_dest = '0;
    s_desc_port_src = '0;
    s_desc_port_dest = '0;
    s_desc_payload_len = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_tlast", 64'(m_axis_tlast), 0);
    chk("rst_tkeep", 64'(m_axis_tkeep), 0);
    chk("rst_tdata_nz", 64'(m_axis_tdata != '0), 0);
    chk("rst_len_err", 64'(m_len_err), 0);
    chk("rst_s_tready", 64'(s_axis_tready), 0);
    chk("rst_desc_ready", 64'(s_desc_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;

    run_frame(32'h0A000001, 32'h0A000002, 16'd3, 16'd80, 16'd22, 22, 0);
    wait_done("t1");
    chk("t1_latency", 64'(first_v_cyc - acc_cyc), 2);
    chk("t1_beats", 64'(got.size()), 2);
    if (got.size() >= 2) begin
      chk("t1_keep1", 64'(got[1].keep), 64'hFFFFFFFF);
      chk("t1_last1", 64'(got[1].last), 1);
      chk("t1_iplen", 64'({got[0].data[16*8 +: 8], got[0].data[17*8 +: 8]}),
          64'h0032);
      chk("t1_udplen", 64'({got[1].data[6*8 +: 8], got[1].data[7*8 +: 8]}),
          64'h001E);
      chk("t1_proto", 64'(got[0].data[23*8 +: 8]), 64'h11);
      chk("t1_etype", 64'({got[0].data[12*8 +: 8], got[0].data[13*8 +: 8]}),
          64'h0800);
    end

    run_frame(32'h0A000001, 32'h0A000002, 16'd3, 16'd80, 16'd23, 23, 0);
    wait_done("t2");
    chk("t2_beats", 64'(got.size()), 3);
    if (got.size() >= 3) begin
      chk("t2_keep2", 64'(got[2].keep), 64'h1);
      chk("t2_last2", 64'(got[2].last), 1);
      chk("t2_byte22", 64'(got[2].data[7:0]), 64'(last_pay[22]));
    end

    run_frame(32'h01020304, 32'h05060708, 16'd9, 16'd10, 16'd0, 0, 0);
    wait_done("t3");
    chk("t3_beats", 64'(got.size()), 2);
    if (got.size() >= 2) begin
      chk("t3_keep1", 64'(got[1].keep), 64'h3FF);
      chk("t3_last1", 64'(got[1].last), 1);
    end
    chk("t3_no_in_ready", 64'(saw_in_ready), 0);

    ready_mode = 1;
    run_frame(32'hC0A80A01, 32'hC0A80A02, 16'd1234, 16'd5678,
              16'd100, 100, 40);
    wait_done("t4");
    chk("t4_bytes", 64'(bytes_seen), 142);
    ready_mode = 0;

`ifdef PANIC_TX_IP_CSUM_EN
    exp_cs = 16'hB861;
`else
    exp_cs = 16'h0000;
`endif
    run_frame(32'hC0A80001, 32'hC0A800C7, 16'd7, 16'd8, 16'd87, 87, 20);
    wait_done("t5");
    if (got.size() >= 1)
      chk("t5_csum", 64'({got[0].data[24*8 +: 8], got[0].data[25*8 +: 8]}),
          64'(exp_cs));

    run_frame(32'h0A000001, 32'h0A000002, 16'd3, 16'd80, 16'd30, 22, 0);
    wait_done("t6");
    chk("t6_err_cycles", 64'(err_cycles), 1);

    // abandon a frame while its first header beat is held downstream
    ready_mode = 3;
    repeat (2) @(posedge clk);
    send_desc(32'h11111111, 32'h22222222, 16'd1, 16'd2, 16'd40, ok);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_held_valid", 64'(m_axis_tvalid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_tvalid", 64'(m_axis_tvalid), 0);
    chk("abort_tlast", 64'(m_axis_tlast), 0);
    chk("abort_desc_ready", 64'(s_desc_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    run_frame(32'h0A000001, 32'h0A000002, 16'd3, 16'd80, 16'd45, 45, 0);
    wait_done("post_rst");
    chk("post_rst_latency", 64'(first_v_cyc - acc_cyc), 2);
    chk("post_rst_bytes", 64'(bytes_seen), 87);

    for (int n = 0; n < 20; n++) begin
      ready_mode = $urandom_range(0, 2);
      dlen = 16'($urandom_range(0, 150));
      run_frame($urandom, $urandom, 16'($urandom), 16'($urandom),
                dlen, int'(dlen), $urandom_range(0, 50));
      wait_done("rand");
      chk("rand_bytes", 64'(bytes_seen), 64'(42 + int'(dlen)));
    end

    chk("final_sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
